// File: rtl/sextium_avalon_io_buffered.sv
// Sextium III CPU I/O strobe bridge to an Avalon-MM master with registered bus outputs,
// a write-posting buffer and reads ordered behind all posted writes.
module sextium_avalon_io_buffered #(
   parameter int unsigned DATA_WIDTH      = 16,
   parameter logic [31:0] READ_FIFO_ADDR  = 32'h200006,
   parameter logic [31:0] WRITE_FIFO_ADDR = 32'h200008,
   parameter int unsigned WBUF_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   output logic [31:0]                   address,
   output logic                          read,
   input  logic [31:0]                   readdata,
   input  logic                          waitrequest,
   output logic                          write,
   output logic [31:0]                   writedata,
   output logic [3:0]                    byteenable,
   output logic [DATA_WIDTH-1:0]         io_bus_in,
   input  logic [DATA_WIDTH-1:0]         io_bus_out,
   input  logic                          io_read,
   input  logic                          io_write,
   output logic                          io_ack,
   output logic [$clog2(WBUF_DEPTH):0]   wbuf_level
);

   localparam int unsigned PW       = $clog2(WBUF_DEPTH);
   localparam logic [PW:0] LVL_FULL = (PW+1)'(WBUF_DEPTH);
   localparam logic [3:0]  BE_MASK  = 4'((5'd1 << (DATA_WIDTH / 8)) - 5'd1);

   if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_width
      $error("DATA_WIDTH must be 8, 16 or 32");
   end
   if (WBUF_DEPTH < 2 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("WBUF_DEPTH must be a power of two, at least 2");
   end

   typedef enum logic [1:0] {StIdle, StWrite, StRead, StRdone} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] mem [WBUF_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  empty;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic [31:0]           head_ext;
   logic                  unused_hi;

   assign empty      = (wbuf_level == '0);
   assign full       = (wbuf_level == LVL_FULL);
   // Read wins over a simultaneous write; the write simply waits unacked.
   assign push       = io_write & ~io_read & ~full;
   assign pop        = (state == StWrite) & ~waitrequest;
   assign io_ack     = push | (state == StRdone);
   assign byteenable = BE_MASK;
   assign head_ext   = 32'(mem[rd_ptr]);
   assign unused_hi  = ^(readdata >> DATA_WIDTH);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= io_bus_out;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wbuf_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   wbuf_level <= wbuf_level + (PW+1)'(1);
            2'b01:   wbuf_level <= wbuf_level - (PW+1)'(1);
            default: wbuf_level <= wbuf_level;
         endcase
      end
   end

   // Draining the buffer before starting a read keeps reads behind posted writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= StIdle;
         address   <= '0;
         read      <= 1'b0;
         write     <= 1'b0;
         writedata <= '0;
         io_bus_in <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (!empty) begin
                  address   <= WRITE_FIFO_ADDR;
                  writedata <= head_ext;
                  write     <= 1'b1;
                  state     <= StWrite;
               end else if (io_read) begin
                  address <= READ_FIFO_ADDR;
                  read    <= 1'b1;
                  state   <= StRead;
               end
            end
            StWrite: begin
               if (!waitrequest) begin
                  write <= 1'b0;
                  state <= StIdle;
               end
            end
            StRead: begin
               if (!waitrequest) begin
                  io_bus_in <= readdata[DATA_WIDTH-1:0];
                  read      <= 1'b0;
                  state     <= StRdone;
               end
            end
            StRdone: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sextium_avalon_io_buffered.sv
// Directed bench for sextium_avalon_io_buffered: vector table plus hand sequences for
// buffer-full stalls, read ordering, wait states and asynchronous reset.
module tb_sextium_avalon_io_buffered;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] address;
   logic        read;
   logic [31:0] readdata;
   logic        waitrequest;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [15:0] io_bus_in;
   logic [15:0] io_bus_out;
   logic        io_read;
   logic        io_write;
   logic        io_ack;
   logic [2:0]  wbuf_level;

   int checks = 0;
   int errors = 0;
   int both_high = 0;
   bit auto_ws = 0;
   int ws_n = 0;
   int ws_cnt = 0;

   typedef struct packed {
      logic        is_wr;
      logic [31:0] addr;
      logic [31:0] data;
   } xfer_t;
   xfer_t xlog[$];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] bus;
      logic        ws;
      logic [31:0] rdata;
      logic        e_ack;
      logic        e_rd;
      logic        e_wr;
      logic [31:0] e_addr;
      logic [31:0] e_wd;
      logic [15:0] e_bin;
      logic [2:0]  e_lvl;
   } vec_t;
   vec_t vecs [17];

   sextium_avalon_io_buffered dut (
      .clk         (clk),
      .reset       (reset),
      .address     (address),
      .read        (read),
      .readdata    (readdata),
      .waitrequest (waitrequest),
      .write       (write),
      .writedata   (writedata),
      .byteenable  (byteenable),
      .io_bus_in   (io_bus_in),
      .io_bus_out  (io_bus_out),
      .io_read     (io_read),
      .io_write    (io_write),
      .io_ack      (io_ack),
      .wbuf_level  (wbuf_level)
   );

   always #5 clk = ~clk;

   // Transfers are accepted on the next rising edge; record them half a cycle early.
   always @(negedge clk) begin
      if (!reset) begin
         if (read && write) both_high++;
         if (write && !waitrequest) xlog.push_back({1'b1, address, writedata});
         if (read && !waitrequest) xlog.push_back({1'b0, address, 32'h0});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_ws) begin
         if (read || write) begin
            if (ws_cnt < ws_n) begin
               waitrequest = 1'b1;
               ws_cnt++;
            end else begin
               waitrequest = 1'b0;
               ws_cnt = 0;
            end
         end else begin
            waitrequest = 1'b0;
            ws_cnt = 0;
         end
      end
      #1;
   endtask

   task automatic wait_ack(input string name);
      bit got = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         #1;
         if (io_ack) begin
            got = 1;
            break;
         end
      end
      chk(name, {31'b0, got}, 32'd1);
   endtask

   initial begin
      //          rd    wr    bus       ws    rdata          ack   rd    wr    addr          wd            bin       lvl
      vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        16'h0,    3'd0};
      vecs[1]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,       32'h0,        16'h0,    3'd0};
      vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        16'h0,    3'd1};
      vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h200008,  32'h00001234, 16'h0,    3'd1};
      vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h200008,  32'h00001234, 16'h0,    3'd0};
      vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 32'h1111ABCD, 1'b0, 1'b0, 1'b0, 32'h200008,  32'h00001234, 16'h0,    3'd0};
      vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 32'h1111ABCD, 1'b0, 1'b1, 1'b0, 32'h200006,  32'h00001234, 16'h0,    3'd0};
      vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 32'h1111ABCD, 1'b1, 1'b0, 1'b0, 32'h200006,  32'h00001234, 16'hABCD, 3'd0};
      vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h200006,  32'h00001234, 16'hABCD, 3'd0};
      vecs[9]  = '{1'b1, 1'b1, 16'h5555, 1'b0, 32'h0000BEEF, 1'b0, 1'b0, 1'b0, 32'h200006,  32'h00001234, 16'hABCD, 3'd0};
      vecs[10] = '{1'b1, 1'b1, 16'h5555, 1'b0, 32'h0000BEEF, 1'b0, 1'b1, 1'b0, 32'h200006,  32'h00001234, 16'hABCD, 3'd0};
      vecs[11] = '{1'b1, 1'b1, 16'h5555, 1'b0, 32'h0000BEEF, 1'b1, 1'b0, 1'b0, 32'h200006,  32'h00001234, 16'hBEEF, 3'd0};
      vecs[12] = '{1'b0, 1'b1, 16'h5555, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h200006,  32'h00001234, 16'hBEEF, 3'd0};
      vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h200006,  32'h00001234, 16'hBEEF, 3'd1};
      vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 32'h200008,  32'h00005555, 16'hBEEF, 3'd1};
      vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h200008,  32'h00005555, 16'hBEEF, 3'd1};
      vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h200008,  32'h00005555, 16'hBEEF, 3'd0};

      reset = 1'b1;
      readdata = '0;
      waitrequest = 1'b0;
      io_bus_out = '0;
      io_read = 1'b0;
      io_write = 1'b0;
      tick();
      tick();
      chk("rst_read", read, 0);
      chk("rst_write", write, 0);
      chk("rst_address", address, 0);
      chk("rst_writedata", writedata, 0);
      chk("rst_io_bus_in", io_bus_in, 0);
      chk("rst_level", wbuf_level, 0);
      chk("rst_ack", io_ack, 0);
      chk("byteenable", byteenable, 4'b0011);
      reset = 1'b0;

      // Table: single posted write, zero-wait read, read/write collision, write with a stall.
      for (int i = 0; i < 17; i++) begin
         tick();
         io_read = vecs[i].rd;
         io_write = vecs[i].wr;
         io_bus_out = vecs[i].bus;
         waitrequest = vecs[i].ws;
         readdata = vecs[i].rdata;
         #1;
         chk($sformatf("row%0d_ack", i), io_ack, vecs[i].e_ack);
         chk($sformatf("row%0d_read", i), read, vecs[i].e_rd);
         chk($sformatf("row%0d_write", i), write, vecs[i].e_wr);
         chk($sformatf("row%0d_address", i), address, vecs[i].e_addr);
         chk($sformatf("row%0d_writedata", i), writedata, vecs[i].e_wd);
         chk($sformatf("row%0d_io_bus_in", i), io_bus_in, vecs[i].e_bin);
         chk($sformatf("row%0d_level", i), wbuf_level, vecs[i].e_lvl);
      end

      // Read with three wait states: request held, single-cycle ack.
      begin
         int rd_cycles = 0;
         bit got = 0;
         auto_ws = 1;
         ws_n = 3;
         tick();
         io_read = 1'b1;
         readdata = 32'hFFFF5678;
         #1;
         for (int i = 0; i < 40; i++) begin
            tick();
            #1;
            if (read) begin
               rd_cycles++;
               chk("ws_addr_held", address, 32'h200006);
               chk("ws_no_write", write, 0);
            end
            if (io_ack) begin
               got = 1;
               break;
            end
         end
         chk("ws_ack_seen", {31'b0, got}, 1);
         chk("ws_read_cycles", rd_cycles, 4);
         chk("ws_io_bus_in", io_bus_in, 16'h5678);
         io_read = 1'b0;
         tick();
         #1;
         chk("ws_ack_pulse", io_ack, 0);
      end

      // Two posted writes then a read, two wait states per transfer.
      ws_n = 2;
      tick();
      xlog.delete();
      readdata = 32'h0000C0DE;
      io_write = 1'b1;
      io_bus_out = 16'hB001;
      #1;
      chk("ord_ack1", io_ack, 1);
      tick();
      io_bus_out = 16'hB002;
      #1;
      chk("ord_ack2", io_ack, 1);
      tick();
      io_write = 1'b0;
      io_read = 1'b1;
      wait_ack("ord_read_ack");
      chk("ord_io_bus_in", io_bus_in, 16'hC0DE);
      io_read = 1'b0;
      chk("ord_count", xlog.size(), 3);
      if (xlog.size() == 3) begin
         chk("ord_x0", {xlog[0].is_wr, xlog[0].data[15:0]}, {1'b1, 16'hB001});
         chk("ord_x1", {xlog[1].is_wr, xlog[1].data[15:0]}, {1'b1, 16'hB002});
         chk("ord_x2", {xlog[2].is_wr, xlog[2].addr}, {1'b0, 32'h200006});
      end
      tick();
      auto_ws = 0;

      // Buffer full while the bus stalls; the fifth write waits for a pop.
      waitrequest = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         io_write = 1'b1;
         io_bus_out = 16'hA001 + 16'(i);
         #1;
         chk($sformatf("full_ack%0d", i), io_ack, 1);
      end
      tick();
      io_bus_out = 16'hA005;
      #1;
      chk("full_level4", wbuf_level, 4);
      chk("full_ack_blocked", io_ack, 0);
      chk("full_write_on", write, 1);
      chk("full_wd_head", writedata, 32'h0000A001);
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         chk("full_stall_ack", io_ack, 0);
         chk("full_stall_wd", writedata, 32'h0000A001);
      end
      tick();
      xlog.delete();
      waitrequest = 1'b0;
      #1;
      chk("full_release_ack", io_ack, 0);
      tick();
      #1;
      chk("full_after_pop_level", wbuf_level, 3);
      chk("full_5th_ack", io_ack, 1);
      tick();
      io_write = 1'b0;
      #1;
      chk("full_refill_level", wbuf_level, 4);
      chk("full_next_wd", writedata, 32'h0000A002);
      for (int i = 0; i < 40; i++) begin
         if (wbuf_level == 0 && !write) break;
         tick();
         #1;
      end
      chk("full_drained", wbuf_level, 0);
      chk("full_count", xlog.size(), 5);
      for (int i = 0; i < 5 && i < xlog.size(); i++) begin
         chk($sformatf("full_order%0d", i), xlog[i].data, 32'h0000A001 + 32'(i));
      end

      // Asynchronous reset during a stalled write with a partly full buffer, then during a read.
      xlog.delete();
      waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         io_write = 1'b1;
         io_bus_out = 16'hC001 + 16'(i);
      end
      tick();
      io_write = 1'b0;
      #1;
      chk("rstw_pre_write", write, 1);
      chk("rstw_pre_level", wbuf_level, 3);
      reset = 1'b1;
      #1;
      chk("rstw_write", write, 0);
      chk("rstw_level", wbuf_level, 0);
      chk("rstw_address", address, 0);
      chk("rstw_ack", io_ack, 0);
      reset = 1'b0;
      tick();
      io_read = 1'b1;
      tick();
      #1;
      chk("rstr_pre_read", read, 1);
      reset = 1'b1;
      #1;
      chk("rstr_read", read, 0);
      chk("rstr_write", write, 0);
      chk("rstr_level", wbuf_level, 0);
      chk("rstr_ack", io_ack, 0);
      io_read = 1'b0;
      reset = 1'b0;
      tick();
      #1;
      chk("rstr_after_ack", io_ack, 0);
      chk("rstr_after_read", read, 0);
      chk("rst_no_xfer", xlog.size(), 0);

      chk("read_write_exclusive", both_high, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
